serial_host: RTL and testbench

//  Initiator for the FT245-style byte protocol used by the serial register block.

---
 rtl/serial_host.sv | 219 +++++++++++++++++++++
 tb/tb_serial_host.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_host.sv
// serial_host: initiator side of the FT245-style byte protocol.
// Turns one register request into a command byte plus four data strobes
// (write bytes out or read bytes in, LSB first) and reports completion.
//
// Handshake: req is sampled only while idle (busy=0). Once accepted, the
// request fields are latched and further req/req_* activity is ignored
// until the cycle after the done pulse. done is a single-cycle pulse and
// rdata is valid from that cycle and held until the next read completes.
module serial_host #(
    parameter int unsigned GAP       = 2,
    parameter logic [3:0]  READ_CMD  = 4'hA,
    parameter logic [3:0]  WRITE_CMD = 4'h5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_rw,
    input  logic [3:0]  req_adr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        _ft_rxf,
    output logic        _ft_rd,
    output logic        _ft_wr,
    output logic [7:0]  ft_byte_out,
    input  logic [7:0]  ft_byte_in,
    output logic [2:0]  dbg_state
);

    // Writes need at least two quiet cycles after the last strobe so the
    // responder can commit; with GAP >= 2 the last gap already covers it.
    localparam int unsigned TAIL_CYC  = (GAP < 2) ? (2 - GAP) : 0;
    localparam logic [3:0]  GAP_LAST  = 4'(GAP - 1);
    localparam logic [3:0]  TAIL_LAST = (TAIL_CYC > 0) ? 4'(TAIL_CYC - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_CGAP = 3'd2,
        S_STB  = 3'd3,
        S_SGAP = 3'd4,
        S_TAIL = 3'd5,
        S_DONE = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic [3:0]  adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rxf_q, rxf_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  idx_inc;

    assign idx_inc = idx_q + 2'd1;

    // Next-state and next-output logic; strobes default high so every low
    // lasts exactly the one cycle it is requested for.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        rxf_d   = 1'b1;
        rd_d    = 1'b1;
        wr_d    = 1'b1;
        byte_d  = byte_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    rw_d    = req_rw;
                    adr_d   = req_adr;
                    wdata_d = req_wdata;
                    idx_d   = 2'd0;
                    rbuf_d  = 32'h0;
                    rxf_d   = 1'b0;
                    byte_d  = {req_adr, (req_rw ? WRITE_CMD : READ_CMD)};
                    busy_d  = 1'b1;
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                // Present write byte 0 for the whole command gap.
                cnt_d   = GAP_LAST;
                byte_d  = rw_q ? wdata_q[7:0] : 8'h00;
                state_d = S_CGAP;
            end

            S_CGAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STB;
                    rd_d    = rw_q;
                    wr_d    = !rw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_STB: begin
                // The next write byte goes out as soon as the strobe ends.
                cnt_d   = GAP_LAST;
                state_d = S_SGAP;
                if (rw_q && (idx_q != 2'd3)) begin
                    byte_d = wdata_q[{idx_inc, 3'b000} +: 8];
                end
            end

            S_SGAP: begin
                // Responder answers a read strobe one cycle later.
                if (!rw_q && (cnt_q == GAP_LAST)) begin
                    rbuf_d[{idx_q, 3'b000} +: 8] = ft_byte_in;
                end
                if (cnt_q == 4'd0) begin
                    if (idx_q == 2'd3) begin
                        if (rw_q && (TAIL_CYC != 0)) begin
                            cnt_d   = TAIL_LAST;
                            state_d = S_TAIL;
                        end else begin
                            done_d  = 1'b1;
                            byte_d  = 8'h00;
                            state_d = S_DONE;
                            if (!rw_q) begin
                                rdata_d = rbuf_d;
                            end
                        end
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_STB;
                        rd_d    = rw_q;
                        wr_d    = !rw_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_TAIL: begin
                if (cnt_q == 4'd0) begin
                    done_d  = 1'b1;
                    byte_d  = 8'h00;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            adr_q   <= 4'h0;
            wdata_q <= 32'h0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            rbuf_q  <= 32'h0;
            rdata_q <= 32'h0;
            rxf_q   <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            byte_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            rxf_q   <= rxf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign _ft_rxf     = rxf_q;
    assign _ft_rd      = rd_q;
    assign _ft_wr      = wr_q;
    assign ft_byte_out = byte_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_host.sv
// Bench for serial_host: a GAP=2 host talking to a behavioural register
// responder, plus a GAP=1 host used for exact cycle timing.
`timescale 1ns/1ps
module tb_serial_host;

    localparam int G = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- GAP=2 instance ----------------
    logic        req = 1'b0, req_rw = 1'b0;
    logic [3:0]  req_adr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, done;
    logic [31:0] rdata;
    logic        ft_rxf_n, ft_rd_n, ft_wr_n;
    logic [7:0]  ft_byte_out, ft_byte_in;
    logic [2:0]  dbg_state;

    serial_host #(.GAP(G)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_adr(req_adr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .rdata(rdata), ._ft_rxf(ft_rxf_n), ._ft_rd(ft_rd_n), ._ft_wr(ft_wr_n),
        .ft_byte_out(ft_byte_out), .ft_byte_in(ft_byte_in), .dbg_state(dbg_state)
    );

    // ---------------- GAP=1 instance ----------------
    logic        g1_req = 1'b0, g1_rw = 1'b0;
    logic [3:0]  g1_adr = 4'h0;
    logic [31:0] g1_wdata = 32'h0;
    logic        g1_busy, g1_done;
    logic [31:0] g1_rdata;
    logic        g1_ft_rxf, g1_ft_rd, g1_ft_wr;
    logic [7:0]  g1_byte_out;
    logic [7:0]  g1_byte_in = 8'h3C;
    logic [2:0]  g1_dbg;

    serial_host #(.GAP(1)) dut_g1 (
        .clk(clk), .reset(reset), .req(g1_req), .req_rw(g1_rw),
        .req_adr(g1_adr), .req_wdata(g1_wdata), .busy(g1_busy), .done(g1_done),
        .rdata(g1_rdata), ._ft_rxf(g1_ft_rxf), ._ft_rd(g1_ft_rd), ._ft_wr(g1_ft_wr),
        .ft_byte_out(g1_byte_out), .ft_byte_in(g1_byte_in), .dbg_state(g1_dbg)
    );

    // ---------------- register map rules ----------------
    function automatic logic [31:0] reset_val(input logic [3:0] a);
        return 32'hC0DE_0000 | {28'h0, a};
    endfunction

    function automatic logic is_writable(input logic [3:0] a);
        return !(a == 4'd5 || a == 4'd7 || a == 4'd10 || a == 4'd15);
    endfunction

    // What a read of adr returns given the value last stored there.
    function automatic logic [31:0] visible(input logic [3:0] a, input logic [31:0] stored);
        case (a)
            4'd15:   return 32'hDEADBEEF;
            4'd5:    return 32'h0505_5EAD;
            4'd7:    return 32'h0707_5EAD;
            4'd10:   return 32'h0A0A_5EAD;
            4'd2:    return stored & ~32'h0000_4000;
            default: return stored;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] v, input int k);
        return 8'(v >> (8 * k));
    endfunction

    // ---------------- responder (bus-functional) ----------------
    logic [31:0] rsp_regs [16];
    logic [7:0]  rsp_cmd;
    int          rsp_idx;
    logic [31:0] rsp_wbuf;

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 16; a++) rsp_regs[a] <= reset_val(4'(a));
            rsp_cmd    <= 8'h00;
            rsp_idx    <= 0;
            rsp_wbuf   <= 32'h0;
            ft_byte_in <= 8'h00;
        end else begin
            if (!ft_rxf_n) begin
                rsp_cmd <= ft_byte_out;
                rsp_idx <= 0;
            end else if (!ft_rd_n) begin
                ft_byte_in <= byte_of(visible(rsp_cmd[7:4], rsp_regs[rsp_cmd[7:4]]), rsp_idx);
                rsp_idx    <= rsp_idx + 1;
            end else if (!ft_wr_n) begin
                rsp_wbuf[8*rsp_idx +: 8] <= ft_byte_out;
                rsp_idx <= rsp_idx + 1;
                if (rsp_idx == 3 && is_writable(rsp_cmd[7:4]))
                    rsp_regs[rsp_cmd[7:4]] <= {ft_byte_out, rsp_wbuf[23:0]};
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    int n_cmp = 0, n_err = 0;
    int n_rxf, n_rd, n_wr, n_done, n_both = 0;
    logic [7:0] seen_q[$];
    logic [7:0] exp_q[$];
    int g1_rxf_q[$], g1_stb_q[$], g1_done_q[$];
    int g1_rd_cnt, g1_wr_cnt;
    logic [7:0] state_seen = 8'h0;
    logic [31:0] exp_regs [16];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        state_seen[dbg_state] = 1'b1;
        state_seen[g1_dbg]    = 1'b1;
        if (!reset) begin
            if (!ft_rxf_n) begin n_rxf++; seen_q.push_back(ft_byte_out); end
            if (!ft_rd_n) n_rd++;
            if (!ft_wr_n) begin n_wr++; seen_q.push_back(ft_byte_out); end
            if (!ft_rd_n && !ft_wr_n) n_both++;
            if (done) n_done++;
            if (!g1_ft_rxf) g1_rxf_q.push_back(cyc);
            if (!g1_ft_rd || !g1_ft_wr) g1_stb_q.push_back(cyc);
            if (!g1_ft_rd) g1_rd_cnt++;
            if (!g1_ft_wr) g1_wr_cnt++;
            if (!g1_ft_rd && !g1_ft_wr) n_both++;
            if (g1_done) g1_done_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        check({tag, "_rxf"},   ft_rxf_n, 1'b1);
        check({tag, "_rd"},    ft_rd_n, 1'b1);
        check({tag, "_wr"},    ft_wr_n, 1'b1);
        check({tag, "_byte"},  ft_byte_out, 8'h00);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_rdata"}, rdata, 32'h0);
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of an idle cycle.
    task automatic do_txn(input logic rw, input logic [3:0] adr, input logic [31:0] wd,
                          input logic noise, output logic [31:0] rd);
        int t0, lat, exp_lat;
        logic got;
        n_rxf = 0; n_rd = 0; n_wr = 0; n_done = 0;
        seen_q.delete(); exp_q.delete();
        exp_q.push_back({adr, (rw ? 4'h5 : 4'hA)});
        if (rw) for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(wd, k));
        exp_lat = rw ? (6 + 4*G + ((G > 2) ? G : 2)) : (6 + 5*G);
        req = 1'b1; req_rw = rw; req_adr = adr; req_wdata = wd; t0 = cyc;
        got = 1'b0; lat = -1; rd = 32'hx;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (noise) begin
                req       = 1'($urandom_range(0, 1));
                req_rw    = 1'($urandom_range(0, 1));
                req_adr   = 4'($urandom_range(0, 15));
                req_wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = cyc - t0; rd = rdata;
                check("busy_in_done", busy, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        @(posedge clk); #1;
        check("done_seen", got, 1'b1);
        check(rw ? "write_latency" : "read_latency", lat, exp_lat);
        check("rxf_lows", n_rxf, 1);
        check("rd_lows", n_rd, rw ? 0 : 4);
        check("wr_lows", n_wr, rw ? 4 : 0);
        check("done_pulses", n_done, 1);
        check("byte_count", seen_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < seen_q.size(); k++)
            check("byte_out", seen_q[k], exp_q[k]);
    endtask

    task automatic g1_run(input logic rw, input logic [31:0] wd, input logic [31:0] exp_rdata);
        int t0;
        g1_rxf_q.delete(); g1_stb_q.delete(); g1_done_q.delete();
        g1_rd_cnt = 0; g1_wr_cnt = 0;
        g1_req = 1'b1; g1_rw = rw; g1_adr = 4'h9; g1_wdata = wd; t0 = cyc;
        @(posedge clk); #1;
        g1_req = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("g1_rxf_count", g1_rxf_q.size(), 1);
        for (int k = 0; k < g1_rxf_q.size(); k++) check("g1_rxf_cycle", g1_rxf_q[k] - t0, 1);
        check("g1_strobe_count", g1_stb_q.size(), 4);
        for (int k = 0; k < g1_stb_q.size() && k < 4; k++)
            check("g1_strobe_cycle", g1_stb_q[k] - t0, 3 + 2*k);
        check("g1_rd_lows", g1_rd_cnt, rw ? 0 : 4);
        check("g1_wr_lows", g1_wr_cnt, rw ? 4 : 0);
        check("g1_done_count", g1_done_q.size(), 1);
        for (int k = 0; k < g1_done_q.size(); k++)
            check(rw ? "g1_write_done" : "g1_read_done", g1_done_q[k] - t0, rw ? 12 : 11);
        check("g1_rdata", g1_rdata, exp_rdata);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rw;
        logic [3:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;   // read result, or held value after a write
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [31:0] rd, wd, exp;
        logic        rw;
        logic [3:0]  adr;
        int d1, r2, d2, w;
        logic found;

        vecs[0] = '{1'b1, 4'h4, 32'hA5A55A5A, 32'h0000_0000};
        vecs[1] = '{1'b0, 4'h4, 32'h0,        32'hA5A55A5A};
        vecs[2] = '{1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 4'h2, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 4'h2, 32'h0,        32'hFFFFBFFF};
        vecs[5] = '{1'b1, 4'h5, 32'h12345678, 32'hFFFFBFFF};
        vecs[6] = '{1'b0, 4'h5, 32'h0,        32'h05055EAD};
        vecs[7] = '{1'b0, 4'h0, 32'h0,        32'hC0DE0000};
        vecs[8] = '{1'b1, 4'h0, 32'h00000000, 32'hC0DE0000};
        vecs[9] = '{1'b0, 4'h0, 32'h0,        32'h00000000};

        for (int a = 0; a < 16; a++) exp_regs[a] = reset_val(4'(a));
        last_rd = 32'h0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("g1_reset_busy", g1_busy, 1'b0);
        check("g1_reset_rxf", g1_ft_rxf, 1'b1);
        @(posedge clk); #1;

        // Directed table.
        for (int v = 0; v < 10; v++) begin
            do_txn(vecs[v].rw, vecs[v].adr, vecs[v].wdata, 1'b0, rd);
            check(vecs[v].rw ? "vec_rdata_hold" : "vec_rdata", rd, vecs[v].exp_rdata);
            if (vecs[v].rw && is_writable(vecs[v].adr)) exp_regs[vecs[v].adr] = vecs[v].wdata;
        end
        last_rd = 32'h0;

        // req held high: back-to-back reads, second CMD two cycles after done.
        n_rxf = 0; n_rd = 0; n_done = 0;
        req = 1'b1; req_rw = 1'b0; req_adr = 4'h3;
        d1 = -1; r2 = -1; d2 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin d1 = cyc; break; end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!ft_rxf_n) begin r2 = cyc; break; end
        end
        check("held_req_restart", r2 - d1, 2);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin d2 = cyc; break; end
        end
        check("held_req_second_latency", d2 - (r2 - 1), 6 + 5*G);
        check("held_req_rdata", rdata, visible(4'h3, exp_regs[3]));
        @(posedge clk); #1;
        check("held_req_rxf_lows", n_rxf, 2);
        check("held_req_rd_lows", n_rd, 8);
        check("held_req_done_pulses", n_done, 2);
        last_rd = visible(4'h3, exp_regs[3]);

        // Random traffic with req/req_* noise while busy.
        for (int n = 0; n < 1000; n++) begin
            rw  = 1'($urandom_range(0, 1));
            adr = 4'($urandom_range(0, 15));
            wd  = $urandom;
            do_txn(rw, adr, wd, 1'b1, rd);
            if (rw) begin
                check("rnd_rdata_hold", rd, last_rd);
                if (is_writable(adr)) exp_regs[adr] = wd;
            end else begin
                exp = visible(adr, exp_regs[adr]);
                check("rnd_read", rd, exp);
                last_rd = exp;
            end
        end

        // Reset in the cycle after write strobe 1.
        n_done = 0;
        req = 1'b1; req_rw = 1'b1; req_adr = 4'h6; req_wdata = 32'h13579BDF;
        @(posedge clk); #1;
        req = 1'b0;
        w = 0; found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!ft_wr_n) w++;
            if (w == 2) begin found = 1'b1; break; end
        end
        check("mid_reset_strobe1_seen", found, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int a = 0; a < 16; a++) exp_regs[a] = reset_val(4'(a));
        last_rd = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        repeat (20) @(posedge clk);
        #1;
        check("mid_reset_no_done", n_done, 0);
        do_txn(1'b0, 4'h6, 32'h0, 1'b0, rd);
        check("mid_reset_readback", rd, reset_val(4'h6));

        // GAP=1 timing.
        g1_run(1'b1, 32'h11223344, 32'h0);
        g1_run(1'b0, 32'h0, 32'h3C3C3C3C);

        check("strobes_never_both_low", n_both, 0);
        $display("states visited mask %b", state_seen);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
